// File: rtl/ccff_loader_pkg.sv
// Purpose: shared types and width helper for the configuration-chain loader.
// Latency: n/a (package only).
// Backpressure: n/a.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  // Bits needed to count from 0 up to and including len.
  function automatic int CCFF_CNT_W(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Purpose: packs serial chain readback bits LSB-first into WORD_W-bit words.
// Latency: word strobed one cycle after its last sample (WORD_W-th bit or final chain bit).
// Backpressure: none; rb_valid is a one-cycle strobe the consumer must take.
// Ports: prog_clk/pReset (sync, active-high); sample_en/bit_in capture one bit;
//        last flushes a short word; rb_data/rb_valid carry the packed word.
module ccff_rb_packer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              last,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CW = CCFF_CNT_W(WORD_W);

  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_acc_nxt;
  logic              w_word_end;

  // Shift form avoids an index wider than the word needs.
  assign w_acc_nxt  = r_acc | (WORD_W'(bit_in) << r_cnt);
  assign w_word_end = (r_cnt == CW'(WORD_W - 1)) || last;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (sample_en) begin
        if (w_word_end) begin
          // Unused upper bits of a short final word stay zero because
          // the accumulator is cleared after every emitted word.
          r_rb_data  <= w_acc_nxt;
          r_rb_valid <= 1'b1;
          r_acc      <= '0;
          r_cnt      <= '0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;

endmodule

// File: rtl/ccff_chain_loader.sv
// Purpose: serialises bitstream words onto a config-FF chain, returns the shifted-out bits, releases I/O isolation when loaded.
// Latency: handshake at t -> bit 0 on ccff_head at t+1; WORD_W+1 cycles per word; done/IO_ISOL_N one cycle after the last shift.
// Backpressure: cfg_ready only in FETCH; an empty input stalls in FETCH with the chain frozen; readback has no backpressure.
// Ports: prog_clk/pReset (sync, active-high); start; cfg_data/cfg_valid/cfg_ready word stream;
//        ccff_head/ccff_clk_en/ccff_tail chain side; rb_data/rb_valid readback; busy, done, IO_ISOL_N status.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              IO_ISOL_N
);

  localparam int BW = CCFF_CNT_W(CHAIN_LEN);
  localparam int WW = CCFF_CNT_W(WORD_W);
  localparam logic [BW-1:0] LEN_B    = BW'(CHAIN_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

  ccff_state_e       r_state;
  ccff_state_e       w_state_nxt;
  logic [WORD_W-1:0] r_sr;
  logic [BW-1:0]     r_bcnt;
  logic [WW-1:0]     r_wcnt;
  logic              r_cfg_ready;
  logic              r_clk_en;
  logic              r_busy;
  logic              r_done;
  logic              r_isol_n;

  logic              w_hs;
  logic              w_start_ok;
  logic              w_word_last;
  logic              w_chain_last;
  logic [BW-1:0]     w_rem;
  logic [WW-1:0]     w_wcnt_ld;

  assign w_hs         = cfg_valid && r_cfg_ready;
  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_word_last  = (r_wcnt == WW'(1));
  assign w_chain_last = (r_bcnt == LAST_BIT);
  assign w_rem        = LEN_B - r_bcnt;

  // Bits of this word that actually go into the chain: a short final
  // word drops its upper bits.
  always_comb begin
    w_wcnt_ld = WW'(WORD_W);
    if (int'(w_rem) < WORD_W) begin
      w_wcnt_ld = WW'(w_rem);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_state_nxt = FETCH;
      FETCH:      if (w_hs) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_word_last) begin
          w_state_nxt = w_chain_last ? DONE : FETCH;
        end
      end
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_cfg_ready <= 1'b0;
      r_clk_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_isol_n    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Status flops are loaded from the next state so every output is a
      // plain register that lines up with the state it describes.
      r_cfg_ready <= (w_state_nxt == FETCH);
      r_clk_en    <= (w_state_nxt == SHIFT);
      r_busy      <= (w_state_nxt == FETCH) || (w_state_nxt == SHIFT);

      if (w_start_ok) begin
        r_bcnt   <= '0;
        r_done   <= 1'b0;
        r_isol_n <= 1'b0;
      end

      if (w_hs) begin
        r_sr   <= cfg_data;
        r_wcnt <= w_wcnt_ld;
      end

      if (r_state == SHIFT) begin
        r_bcnt <= r_bcnt + 1'b1;
        r_wcnt <= r_wcnt - 1'b1;
        // Clearing at the end of a word parks ccff_head low between words
        // and drops the discarded bits of a short final word.
        r_sr   <= w_word_last ? '0 : (r_sr >> 1);
        if (w_word_last && w_chain_last) begin
          r_done   <= 1'b1;
          r_isol_n <= 1'b1;
        end
      end
    end
  end

  ccff_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .sample_en (r_clk_en),
    .bit_in    (ccff_tail),
    .last      (w_chain_last),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
  );

  assign cfg_ready   = r_cfg_ready;
  assign ccff_head   = r_sr[0];
  assign ccff_clk_en = r_clk_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign IO_ISOL_N   = r_isol_n;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Purpose: directed bench for ccff_chain_loader on a 64-bit and a 20-bit chain.
// Latency: readback words are scoreboarded as they are strobed.
// Backpressure: stimulus holds cfg_valid except during a deliberate underrun gap.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       prst, start, cfg_valid, sel;
  logic [7:0] cfg_data;

  logic       rdy64, head64, cen64, rbv64, busy64, done64, isol64, tail64;
  logic [7:0] rbd64;
  logic       rdy20, head20, cen20, rbv20, busy20, done20, isol20, tail20;
  logic [7:0] rbd20;

  // Behavioural chains; the 64-bit one starts preloaded with 0x5A bytes.
  logic [63:0] chain64 = {8{8'h5A}};
  logic [19:0] chain20 = '0;
  assign tail64 = chain64[63];
  assign tail20 = chain20[19];
  always @(posedge clk) if (cen64) chain64 <= {chain64[62:0], head64};
  always @(posedge clk) if (cen20) chain20 <= {chain20[18:0], head20};

  ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) u_dut64 (
    .prog_clk(clk), .pReset(prst), .start(start & ~sel), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid & ~sel), .cfg_ready(rdy64), .ccff_head(head64),
    .ccff_clk_en(cen64), .ccff_tail(tail64), .rb_data(rbd64), .rb_valid(rbv64),
    .busy(busy64), .done(done64), .IO_ISOL_N(isol64));

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .prog_clk(clk), .pReset(prst), .start(start & sel), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid & sel), .cfg_ready(rdy20), .ccff_head(head20),
    .ccff_clk_en(cen20), .ccff_tail(tail20), .rb_data(rbd20), .rb_valid(rbv20),
    .busy(busy20), .done(done20), .IO_ISOL_N(isol20));

  // Outputs of whichever DUT is currently being exercised.
  logic       m_ready, m_head, m_cen, m_rbv, m_busy, m_done, m_isol;
  logic [7:0] m_rbd;
  assign m_ready = sel ? rdy20  : rdy64;
  assign m_head  = sel ? head20 : head64;
  assign m_cen   = sel ? cen20  : cen64;
  assign m_rbv   = sel ? rbv20  : rbv64;
  assign m_busy  = sel ? busy20 : busy64;
  assign m_done  = sel ? done20 : done64;
  assign m_isol  = sel ? isol20 : isol64;
  assign m_rbd   = sel ? rbd20  : rbd64;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: expected readback words pushed by stimulus, popped on rb_valid.
  logic [7:0] exp_q[$];
  always @(negedge clk) begin
    if (m_rbv) begin
      if (exp_q.size() == 0) begin
        chk("rb_unexpected_strobe", 64'(m_rbd), 64'hDEAD);
      end else begin
        chk("rb_data", 64'(m_rbd), 64'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [63:0] outs();
    return {48'h0, m_rbd, m_ready, m_head, m_cen, m_rbv, m_busy, m_done, m_isol, 1'b0};
  endfunction

  // Runs one load on the selected DUT. gap_at/busy_at/abort_at < 0 disable
  // the underrun gap, the busy-time start pulse and the mid-load reset.
  task automatic run_load(input int nw, input logic [7:0] w[8], input int gap_at,
                          input int busy_at, input int abort_at,
                          output int hs, output int sh);
    int          idx, gap_left, cyc;
    bit          fire, seen_done, rise_ok, bs_done, bs_now, bs_next;
    logic [63:0] gap_snap;
    idx = 0; gap_left = 5; cyc = 0; hs = 0; sh = 0;
    seen_done = 0; rise_ok = 1; bs_done = 0; bs_now = 0; bs_next = 0;
    gap_snap = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_to_fetch", {62'h0, m_ready, m_busy}, 64'h3);
    @(posedge clk); #1;
    while (!seen_done && cyc < 3000) begin
      cfg_valid = (idx < nw) && !(idx == gap_at && gap_left > 0);
      cfg_data  = (idx < nw) ? w[idx] : 8'h00;
      bs_now    = 0;
      if (busy_at >= 0 && !bs_done && sh == busy_at) begin
        start = 1'b1; bs_done = 1; bs_now = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      fire = cfg_valid && m_ready;
      if (fire) hs++;
      if (bs_next) begin
        chk("busy_start_ignored", {62'h0, m_busy, m_ready}, 64'h2);
        bs_next = 0;
      end
      if (bs_now) begin
        chk("busy_start_in_shift", 64'(m_cen), 64'h1);
        bs_next = 1;
      end
      if (idx == gap_at && gap_left > 0 && m_ready) begin
        if (gap_left == 5) gap_snap = chain64;
        chk("underrun_hold", {m_cen, chain64[62:0] ^ gap_snap[62:0]} | 64'(chain64[63] ^ gap_snap[63]),
            64'h0);
        gap_left--;
      end
      if (m_cen) sh++;
      if (m_done !== m_isol) rise_ok = 0;
      if (m_done) seen_done = 1;
      if (abort_at > 0 && sh == abort_at) begin
        prst = 1'b1;
        @(posedge clk); #1 cfg_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_mid_load_outputs", outs(), 64'h0);
        prst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (fire) idx++;
      cyc++;
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    chk("done_seen", 64'(seen_done), 64'h1);
    chk("done_isol_together", 64'(rise_ok), 64'h1);
    @(negedge clk);
    chk("done_hold", {59'h0, m_done, m_isol, m_busy, m_cen, m_ready}, 64'h18);
  endtask

  logic [7:0] wv[8];
  int         hs, sh;

  initial begin
    prst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state_64", outs(), 64'h0);
    sel = 1'b1; #1;
    chk("reset_state_20", outs(), 64'h0);
    sel = 1'b0;
    @(posedge clk); #1 prst = 1'b0;
    repeat (2) @(posedge clk);

    // Full load over a 0x5A-preloaded chain: readback returns the preload.
    wv = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h5A);
    run_load(8, wv, -1, -1, -1, hs, sh);
    chk("full_handshakes", 64'(hs), 64'd8);
    chk("full_shifts", 64'(sh), 64'd64);
    chk("full_chain", chain64, 64'h8040C020A060E010);

    // Zeros with a 5-cycle underrun after word 3 and a start pulse mid-shift.
    wv = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    run_load(8, wv, 3, 20, -1, hs, sh);
    chk("stall_handshakes", 64'(hs), 64'd8);
    chk("stall_shifts", 64'(sh), 64'd64);
    chk("stall_chain", chain64, 64'h0);

    // 0xFF load aborted by reset after 30 shifts.
    wv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
    run_load(8, wv, -1, -1, 30, hs, sh);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_rb_drained", 64'(exp_q.size()), 64'd0);
    chk("abort_chain_partial", chain64, 64'h0000_0000_3FFF_FFFF);
    chk("abort_isolated", {62'h0, m_isol, m_done}, 64'h0);

    // Fresh load after the abort; readback shows the 30 partial bits.
    wv = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFC, 8'hFF, 8'hFF, 8'hFF};
    run_load(8, wv, -1, -1, -1, hs, sh);
    chk("reload_handshakes", 64'(hs), 64'd8);
    chk("reload_shifts", 64'(sh), 64'd64);
    chk("reload_chain", chain64, 64'h8848C828A868E818);

    // 20-bit chain: short final word keeps only its 4 LSBs.
    sel = 1'b1;
    wv = '{8'hFF, 8'h00, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_q = '{8'h00, 8'h00, 8'h00};
    run_load(3, wv, -1, -1, -1, hs, sh);
    chk("partial_handshakes", 64'(hs), 64'd3);
    chk("partial_shifts", 64'(sh), 64'd20);
    chk("partial_chain", 64'(chain20), 64'hFF00D);

    wv = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_q = '{8'hFF, 8'h00, 8'h0B};
    run_load(3, wv, -1, -1, -1, hs, sh);
    chk("partial_rb_handshakes", 64'(hs), 64'd3);
    chk("partial_rb_shifts", 64'(sh), 64'd20);
    chk("partial_rb_chain", 64'(chain20), 64'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
